// File: rtl/threewire_master_burst_if.sv
// Host-side request/handshake and board-side pin bundle of the
// three-wire burst master (the bidirectional data pin stays a plain port).
interface threewire_master_burst_if #(
   parameter int TWM_ADDRESS_BITS = 10,
   parameter int TWM_DATA_BITS    = 32,
   parameter int TWM_NUM_CS       = 2,
   parameter int TWM_BURST_BITS   = 4
);
   localparam int CSW = (TWM_NUM_CS > 1) ? $clog2(TWM_NUM_CS) : 1;

   logic                        in_start;
   logic                        in_mode_wr;
   logic [CSW-1:0]              in_cs_sel;
   logic [TWM_ADDRESS_BITS-1:0] in_addr;
   logic [TWM_BURST_BITS-1:0]   in_burst_len;
   logic [TWM_DATA_BITS-1:0]    in_wr_data;
   logic                        out_wr_req;
   logic [TWM_DATA_BITS-1:0]    out_rd_data;
   logic                        out_rd_valid;
   logic                        out_busy;
   logic                        out_done;
   logic                        out_err;
   logic                        out_tw_clock;
   logic [TWM_NUM_CS-1:0]       out_tw_cs;
   logic                        out_tw_dir;

   modport master (
      input  in_start, in_mode_wr, in_cs_sel, in_addr,
      input  in_burst_len, in_wr_data,
      output out_wr_req, out_rd_data, out_rd_valid,
      output out_busy, out_done, out_err,
      output out_tw_clock, out_tw_cs, out_tw_dir
   );

   modport slave (
      output in_start, in_mode_wr, in_cs_sel, in_addr,
      output in_burst_len, in_wr_data,
      input  out_wr_req, out_rd_data, out_rd_valid,
      input  out_busy, out_done, out_err,
      input  out_tw_clock, out_tw_cs, out_tw_dir
   );
endinterface

// File: rtl/threewire_master_burst.sv
// Three-wire bus master: multiple active-low chip selects, multi-word
// bursts with auto-incrementing slave address, per-word data handshake.
module threewire_master_burst #(
   parameter int TWM_ADDRESS_BITS = 10,
   parameter int TWM_DATA_BITS    = 32,
   parameter int TWM_CLK_DIV_2N   = 4,
   parameter int TWM_NUM_CS       = 2,
   parameter int TWM_BURST_BITS   = 4
) (
   input  logic                    in_clk,
   input  logic                    in_rst,
   threewire_master_burst_if.master bus,
   inout  wire                     io_tw_data
);
   localparam int A    = TWM_ADDRESS_BITS;
   localparam int D    = TWM_DATA_BITS;
   localparam int CW   = $clog2(TWM_CLK_DIV_2N);
   localparam int CSW  = (TWM_NUM_CS > 1) ? $clog2(TWM_NUM_CS) : 1;
   localparam int MAXB = (A > D) ? A : D;
   localparam int BCW  = $clog2(MAXB);
   localparam int WCW  = TWM_BURST_BITS + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READY = 3'd1;
   localparam logic [2:0] S_RW    = 3'd2;
   localparam logic [2:0] S_ADDR  = 3'd3;
   localparam logic [2:0] S_WDATA = 3'd4;
   localparam logic [2:0] S_TURN  = 3'd5;
   localparam logic [2:0] S_RDATA = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   logic [CW-1:0]             clk_div_ctr;
   logic                      tick;
   logic [2:0]                state;
   logic                      busy_q;
   logic                      done_q;
   logic                      err_q;
   logic                      wr_req_q;
   logic                      rd_valid_q;
   logic [D-1:0]              rd_data_q;
   logic [TWM_NUM_CS-1:0]     cs_n_q;
   logic                      dir_q;
   logic                      tx_q;
   logic                      mode_q;
   logic [CSW-1:0]            cs_sel_q;
   logic [A-1:0]              addr_sr;
   logic [TWM_BURST_BITS-1:0] len_q;
   logic [D-1:0]              wsr;
   logic [D-2:0]              rsr;
   logic [BCW-1:0]            bit_cnt;
   logic [WCW-1:0]            word_cnt;
   logic                      sel_ok;
   logic                      last_word;
   logic                      last_bit;
   logic                      load_word;

   assign tick      = (clk_div_ctr == CW'(TWM_CLK_DIV_2N - 1));
   assign sel_ok    = ({1'b0, bus.in_cs_sel} < (CSW + 1)'(TWM_NUM_CS));
   assign last_word = (word_cnt == {1'b0, len_q});
   assign last_bit  = (bit_cnt == '0);
   // Words after the first are fetched live from the host at their MSB tick
   assign load_word = (word_cnt != '0) && (bit_cnt == BCW'(D - 1));

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) clk_div_ctr <= '0;
      else        clk_div_ctr <= clk_div_ctr + 1'b1;
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state      <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_req_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         cs_n_q     <= '1;
         dir_q      <= 1'b0;
         tx_q       <= 1'b0;
         mode_q     <= 1'b0;
         cs_sel_q   <= '0;
         addr_sr    <= '0;
         len_q      <= '0;
         wsr        <= '0;
         rsr        <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
      end else begin
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_req_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.in_start) begin
                  if (sel_ok) begin
                     mode_q   <= bus.in_mode_wr;
                     cs_sel_q <= bus.in_cs_sel;
                     addr_sr  <= bus.in_addr;
                     len_q    <= bus.in_burst_len;
                     wsr      <= bus.in_wr_data;
                     word_cnt <= '0;
                     busy_q   <= 1'b1;
                     state    <= S_READY;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_READY: begin
               if (tick) state <= S_RW;
            end
            S_RW: begin
               if (tick) begin
                  cs_n_q  <= ~(TWM_NUM_CS'(1) << cs_sel_q);
                  tx_q    <= mode_q;
                  bit_cnt <= BCW'(A - 1);
                  state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (tick) begin
                  tx_q    <= addr_sr[A-1];
                  addr_sr <= addr_sr << 1;
                  if (last_bit) begin
                     bit_cnt <= BCW'(D - 1);
                     state   <= mode_q ? S_WDATA : S_TURN;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
            end
            S_WDATA: begin
               if (tick) begin
                  if (load_word) begin
                     tx_q <= bus.in_wr_data[D-1];
                     wsr  <= bus.in_wr_data << 1;
                  end else begin
                     tx_q <= wsr[D-1];
                     wsr  <= wsr << 1;
                  end
                  if (last_bit) begin
                     if (last_word) begin
                        state <= S_DONE;
                     end else begin
                        wr_req_q <= 1'b1;
                        word_cnt <= word_cnt + 1'b1;
                        bit_cnt  <= BCW'(D - 1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
            end
            S_TURN: begin
               if (tick) begin
                  dir_q   <= 1'b1;
                  bit_cnt <= BCW'(D - 1);
                  state   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (tick) begin
                  rsr <= (D - 1)'({rsr, io_tw_data});
                  if (last_bit) begin
                     rd_data_q  <= {rsr, io_tw_data};
                     rd_valid_q <= 1'b1;
                     if (last_word) begin
                        state <= S_DONE;
                     end else begin
                        word_cnt <= word_cnt + 1'b1;
                        bit_cnt  <= BCW'(D - 1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (tick) begin
                  cs_n_q <= '1;
                  dir_q  <= 1'b0;
                  tx_q   <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign io_tw_data       = dir_q ? 1'bz : tx_q;
   assign bus.out_tw_clock = clk_div_ctr[CW-1];
   assign bus.out_tw_cs    = cs_n_q;
   assign bus.out_tw_dir   = dir_q;
   assign bus.out_busy     = busy_q;
   assign bus.out_done     = done_q;
   assign bus.out_err      = err_q;
   assign bus.out_wr_req   = wr_req_q;
   assign bus.out_rd_valid = rd_valid_q;
   assign bus.out_rd_data  = rd_data_q;
endmodule

// File: tb/tb_threewire_master_burst.sv
// Bench for threewire_master_burst: bus slave model, transaction-level
// expected bit streams, directed and random bursts.
module tb_threewire_master_burst;
   localparam int A   = 10;
   localparam int D   = 32;
   localparam int DIV = 4;
   localparam int NCS = 3;

   logic in_clk = 1'b0;
   logic in_rst;
   wire  tw_data;

   threewire_master_burst_if #(.TWM_NUM_CS(NCS)) bus ();

   threewire_master_burst #(
      .TWM_ADDRESS_BITS(A), .TWM_DATA_BITS(D), .TWM_CLK_DIV_2N(DIV),
      .TWM_NUM_CS(NCS), .TWM_BURST_BITS(4)
   ) dut (
      .in_clk(in_clk), .in_rst(in_rst), .bus(bus), .io_tw_data(tw_data)
   );

   always #5 in_clk = ~in_clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] wr_words [16];
   logic [31:0] sl_words [16];
   logic [4:0]  host_idx = '0;
   logic        slave_bits [$];
   logic        slave_drv = 1'b0;
   int          slave_k = 0;
   logic        sent_bits [$];
   logic [31:0] rd_q [$];
   logic [2:0]  exp_cs = 3'b111;
   int n_done = 0, n_err = 0, n_wreq = 0, n_rdv = 0;
   int n_cs = 0, n_csbad = 0, n_dir = 0, n_busy = 0;

   // Host: next write word follows each request, word 0 while idle
   assign bus.in_wr_data = wr_words[host_idx[3:0]];
   always @(negedge in_clk)
      if (!bus.out_busy) host_idx <= '0;
      else if (bus.out_wr_req) host_idx <= host_idx + 1'b1;

   // Slave: drives read bits on rising bus clock, master samples later
   assign tw_data = bus.out_tw_dir ? slave_drv : 1'bz;
   always @(posedge bus.out_tw_clock)
      if (bus.out_tw_dir) begin
         slave_drv <= (slave_k < slave_bits.size()) ? slave_bits[slave_k] : 1'b0;
         slave_k   <= slave_k + 1;
      end else begin
         slave_k <= 0;
      end

   always @(posedge bus.out_tw_clock)
      if (bus.out_tw_cs != 3'b111 && !bus.out_tw_dir)
         sent_bits.push_back(tw_data);

   always @(negedge in_clk) begin
      if (bus.out_done) n_done++;
      if (bus.out_err) n_err++;
      if (bus.out_wr_req) n_wreq++;
      if (bus.out_rd_valid) begin
         n_rdv++;
         rd_q.push_back(bus.out_rd_data);
      end
      if (bus.out_tw_cs != 3'b111) n_cs++;
      if (bus.out_tw_cs != 3'b111 && bus.out_tw_cs != exp_cs) n_csbad++;
      if (bus.out_tw_dir) n_dir++;
      if (bus.out_busy) n_busy++;
   end

   task automatic step();
      @(negedge in_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_slave(input int nw);
      slave_bits.delete();
      for (int w = 0; w < nw; w++)
         for (int i = D - 1; i >= 0; i--) slave_bits.push_back(sl_words[w][i]);
   endtask

   task automatic run_txn(input bit mode, input int cs, input logic [9:0] addr,
                          input int len, input bit disturb);
      int  nw = len + 1;
      int  b_sent = sent_bits.size();
      int  b_rd = rd_q.size();
      int  d0 = n_done, e0 = n_err, w0 = n_wreq, r0 = n_rdv;
      int  c0 = n_cs, cb0 = n_csbad, dr0 = n_dir;
      int  mism = 0;
      int  per;
      bit  seen = 0;
      logic exp_bits [$];
      exp_cs = ~(3'b001 << cs);
      exp_bits.push_back(mode);
      for (int i = A - 1; i >= 0; i--) exp_bits.push_back(addr[i]);
      if (mode) begin
         for (int w = 0; w < nw; w++)
            for (int i = D - 1; i >= 0; i--) exp_bits.push_back(wr_words[w][i]);
      end else begin
         load_slave(nw);
      end
      bus.in_start     = 1'b1;
      bus.in_mode_wr   = mode;
      bus.in_cs_sel    = 2'(cs);
      bus.in_addr      = addr;
      bus.in_burst_len = 4'(len);
      step();
      bus.in_start = 1'b0;
      chk("busy_rise", bus.out_busy, 1);
      for (int c = 0; c < 3000 && !seen; c++) begin
         step();
         if (n_done > d0) seen = 1;
         if (disturb && c == 60) begin
            bus.in_start     = 1'b1;
            bus.in_addr      = ~addr;
            bus.in_mode_wr   = ~mode;
            bus.in_cs_sel    = 2'd0;
            bus.in_burst_len = 4'(len + 3);
         end else if (disturb && c == 61) begin
            bus.in_start = 1'b0;
         end
      end
      chk("done_seen", seen, 1);
      step();
      chk("done_cnt", n_done - d0, 1);
      chk("bits_len", sent_bits.size() - b_sent, exp_bits.size());
      for (int i = 0; i < exp_bits.size(); i++)
         if (b_sent + i >= sent_bits.size()) mism++;
         else if (sent_bits[b_sent + i] !== exp_bits[i]) mism++;
      chk("bits", mism, 0);
      per = mode ? (1 + A + nw * D) : (2 + A + nw * D);
      chk("cs_cycles", n_cs - c0, per * DIV);
      chk("cs_select", n_csbad - cb0, 0);
      chk("wr_req", n_wreq - w0, mode ? len : 0);
      chk("rd_valid", n_rdv - r0, mode ? 0 : nw);
      chk("dir_cycles", n_dir - dr0, mode ? 0 : (1 + nw * D) * DIV);
      chk("err_none", n_err - e0, 0);
      if (!mode) begin
         for (int w = 0; w < nw && b_rd + w < rd_q.size(); w++)
            chk("rd_word", rd_q[b_rd + w], sl_words[w]);
         chk("rd_data_out", bus.out_rd_data, sl_words[nw - 1]);
      end
   endtask

   initial begin
      int   e0, c0, bz0, d0, r0, dr0;
      bit   reached;
      logic [9:0] ra;
      in_rst = 1'b1;
      bus.in_start = 1'b0;
      bus.in_mode_wr = 1'b0;
      bus.in_cs_sel = '0;
      bus.in_addr = '0;
      bus.in_burst_len = '0;
      for (int i = 0; i < 16; i++) begin
         wr_words[i] = '0;
         sl_words[i] = '0;
      end
      repeat (3) step();
      chk("rst_cs", bus.out_tw_cs, 3'b111);
      chk("rst_dir", bus.out_tw_dir, 0);
      chk("rst_data", tw_data, 0);
      chk("rst_busy", bus.out_busy, 0);
      chk("rst_rd_data", bus.out_rd_data, 0);
      chk("rst_pulses", {bus.out_done, bus.out_err, bus.out_wr_req, bus.out_rd_valid}, 0);
      chk("rst_clk", bus.out_tw_clock, 0);
      in_rst = 1'b0;
      step();

      wr_words[0] = 32'hDEADBEEF;
      run_txn(1, 1, 10'h2A5, 0, 0);

      sl_words[0] = 32'h12345678;
      run_txn(0, 0, 10'h003, 0, 0);

      wr_words[0] = 32'h11111111;
      wr_words[1] = 32'h22222222;
      wr_words[2] = 32'h33333333;
      run_txn(1, 2, 10'h155, 2, 0);

      e0 = n_err; c0 = n_cs; bz0 = n_busy;
      bus.in_start = 1'b1;
      bus.in_mode_wr = 1'b1;
      bus.in_cs_sel = 2'd3;
      step();
      bus.in_start = 1'b0;
      chk("err_pulse", bus.out_err, 1);
      chk("err_busy", bus.out_busy, 0);
      repeat (8) step();
      chk("err_cnt", n_err - e0, 1);
      chk("err_no_cs", n_cs - c0, 0);
      chk("err_no_busy", n_busy - bz0, 0);

      for (int w = 0; w < 2; w++) sl_words[w] = $urandom;
      load_slave(2);
      exp_cs = 3'b011;
      d0 = n_done; r0 = n_rdv; dr0 = n_dir; reached = 0;
      bus.in_start = 1'b1;
      bus.in_mode_wr = 1'b0;
      bus.in_cs_sel = 2'd2;
      bus.in_addr = 10'h0F0;
      bus.in_burst_len = 4'd1;
      step();
      bus.in_start = 1'b0;
      for (int c = 0; c < 1000 && !reached; c++) begin
         step();
         if (n_dir - dr0 >= 40) reached = 1;
      end
      chk("rst_reach", reached, 1);
      in_rst = 1'b1;
      #1;
      chk("midrst_cs", bus.out_tw_cs, 3'b111);
      chk("midrst_dir", bus.out_tw_dir, 0);
      chk("midrst_busy", bus.out_busy, 0);
      chk("midrst_data", tw_data, 0);
      chk("midrst_rd_data", bus.out_rd_data, 0);
      repeat (2) step();
      in_rst = 1'b0;
      step();
      chk("midrst_no_done", n_done - d0, 0);
      chk("midrst_no_rdv", n_rdv - r0, 0);

      wr_words[0] = $urandom;
      wr_words[1] = $urandom;
      run_txn(1, 0, 10'h2C3, 1, 0);

      wr_words[0] = 32'hA5A5F00F;
      wr_words[1] = 32'h0F0F1234;
      run_txn(1, 1, 10'h155, 1, 1);

      for (int t = 0; t < 6; t++) begin
         for (int w = 0; w < 16; w++) begin
            wr_words[w] = $urandom;
            sl_words[w] = $urandom;
         end
         ra = 10'($urandom);
         run_txn(1'($urandom_range(1, 0)), $urandom_range(2, 0), ra,
                 $urandom_range(3, 0), 0);
      end

      for (int w = 0; w < 16; w++) begin
         wr_words[w] = $urandom;
         sl_words[w] = $urandom;
      end
      run_txn(0, 1, 10'h3FF, 15, 0);
      run_txn(1, 2, 10'h000, 15, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
